cdc_req_arbiter: RTL and testbench
==================================

Name: cdc_req_arbiter

Overview:
Receive-side controller for four-phase req/ack handshakes arriving from foreign clock domains.
- Each asynchronous request passes through an internal chain of SYNC_STAGES flops (async reset replaced by synchronous srst_i).
- Synchronized requests are arbitrated round-robin and presented one at a time as a local valid/ready event.
- Each requester gets a registered level ack_o, which that requester synchronizes in its own domain.
- Sits at SoC domain boundaries: interrupt/doorbell collection, slow-peripheral command hand-off.

Parameters:
- NUM_REQ, 4, number of asynchronous requesters (>=1).
- SYNC_STAGES, 2, synchronizer depth per request (>=2; values <2 are an elaboration error).

Ports:
- clk_i  input  1  local clock; all flops use its rising edge.
- srst_i  input  1  synchronous reset, active-high.
- async_req_i  input  NUM_REQ  four-phase request levels from foreign domains, unsynchronized.
- ack_o  output  NUM_REQ  registered four-phase ack levels, one per requester.
- evt_valid_o  output  1  event offered to local consumer.
- evt_ready_i  input  1  consumer accepts event.
- evt_idx_o  output  IDX_W  index of offered requester; IDX_W = clog2(NUM_REQ), minimum 1.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset and interface:
- One clock. Reset is synchronous and active-high.
- While srst_i is high at a rising edge, all of the following clear to 0 at that edge: sync chains, ack_o, evt_valid_o, evt_idx_o, busy_o, state (to IDLE), and rr_ptr.
- Reset mid-handshake drops ack_o immediately. A requester still holding req high is re-synchronized and re-offered as a new event.

Synchronizer:
- sreq[i] is the last stage of the chain for async_req_i[i].
- Edge k samples req=1 into stage 1; sreq[i] is high after edge k+SYNC_STAGES-1.

Arbitration (IDLE only):
- Candidates are all i with sreq[i]=1.
- Search starts at rr_ptr, ascending, wrapping at NUM_REQ-1 to 0; the first hit wins.
- On a winner g, at the next edge: latch g, evt_idx_o=g, evt_valid_o=1, go to OFFER.
- Latency: req sampled at edge k gives evt_valid_o high after edge k+SYNC_STAGES when the FSM is idle.

States:
- IDLE: no candidate, stay in IDLE.
- OFFER: evt_valid_o=1, evt_idx_o held stable, ack_o all 0. Hold indefinitely while evt_ready_i=0. On an edge with evt_ready_i=1: evt_valid_o<=0, ack_o[g]<=1, rr_ptr<=(g+1) mod NUM_REQ, go to WAIT_LO. If sreq[g] falls during OFFER (protocol violation), the event is still completed.
- WAIT_LO: ack_o[g]=1. When sreq[g]=0 at an edge: ack_o[g]<=0, go to IDLE. No timeout.

Invariants and corner cases:
- At most one ack_o bit is high at any time.
- ack_o is never high together with evt_valid_o.
- Minimum gap between consecutive events is one IDLE cycle, giving one event per 3 + handshake cycles.
- Requests arriving while busy remain pending in the sync chains; none are lost, because four-phase requesters hold req until acked.
- NUM_REQ=1: evt_idx_o is constant 0; rr_ptr is constant 0.
- busy_o = (state != IDLE), registered.

Test Plan:
- Single request, SYNC_STAGES=2, NUM_REQ=4: async_req_i[2] rises before edge 0, evt_ready_i tied 1 → evt_valid_o=1 with evt_idx_o=2 after edge 2; ack_o[2]=1 after edge 3. Drop req → ack_o[2]=0 two edges after the drop is first sampled, then FSM in IDLE.
- Backpressure: hold evt_ready_i=0 for 10 cycles while req[1] is offered → evt_valid_o stays 1, evt_idx_o stays 1, ack_o stays 0. Raise ready → exactly one ack_o[1] pulse sequence.
- Round robin: all four reqs held high, each requester drops req on ack and re-raises it on ack low → evt_idx_o sequence 0,1,2,3,0,1; never two consecutive events to the same index while others are pending.
- Late arrival: req[3] rises while req[0] is in WAIT_LO → req[3] offered immediately after the IDLE cycle following ack_o[0] fall; not lost.
- Reset mid-operation: srst_i pulsed 1 cycle during WAIT_LO with req[1] still high → ack_o=0 and busy_o=0 after that edge. After resync, evt_valid_o reasserts with evt_idx_o=1 and rr_ptr starts at 0.
- Protocol violation: req[2] drops during OFFER → event still accepted and ack_o[2] asserted. Because sreq[2]=0, ack_o[2] clears on the next edge after WAIT_LO is entered; no deadlock.

Source files
------------

// File: rtl/cdc_req_arbiter.sv
// Receive side of four-phase req/ack handshakes from foreign clock domains:
// per-request synchronizers, round-robin arbitration, registered level acks.
module cdc_req_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int SYNC_STAGES = 2,
   localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk_i,
   input  logic               srst_i,
   input  logic [NUM_REQ-1:0] async_req_i,
   output logic [NUM_REQ-1:0] ack_o,
   output logic               evt_valid_o,
   input  logic               evt_ready_i,
   output logic [IDX_W-1:0]   evt_idx_o,
   output logic               busy_o
);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("cdc_req_arbiter: SYNC_STAGES must be >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OFFER   = 2'd1,
      WAIT_LO = 2'd2
   } state_t;

   logic [NUM_REQ-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [NUM_REQ-1:0] sreq;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               evt_valid_q, evt_valid_d;
   logic [IDX_W-1:0]   evt_idx_q, evt_idx_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               busy_q, busy_d;

   logic               found;
   logic [IDX_W-1:0]   win;
   logic               sreq_g;

   always_comb begin
      sync_d = sync_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], async_req_i[i]};
         sreq[i]   = sync_q[i][SYNC_STAGES-1];
      end
   end

   // Two passes: indices at/after rr_ptr first, then the wrapped-around ones.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && sreq[i] && (i >= int'(rr_ptr_q))) begin
            found = 1'b1;
            win   = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && sreq[i]) begin
            found = 1'b1;
            win   = IDX_W'(i);
         end
      end
   end

   // ack_q is one-hot on the granted index while waiting for its req to drop
   assign sreq_g = |(sreq & ack_q);

   always_comb begin
      state_d     = state_q;
      ack_d       = ack_q;
      evt_valid_d = evt_valid_q;
      evt_idx_d   = evt_idx_q;
      rr_ptr_d    = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               evt_idx_d   = win;
               evt_valid_d = 1'b1;
               state_d     = OFFER;
            end
         end
         OFFER: begin
            if (evt_ready_i) begin
               evt_valid_d = 1'b0;
               ack_d       = NUM_REQ'(1) << evt_idx_q;
               rr_ptr_d    = (int'(evt_idx_q) == NUM_REQ - 1) ?
                             '0 : evt_idx_q + 1'b1;
               state_d     = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (!sreq_g) begin
               ack_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            ack_d       = '0;
            evt_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sync_q      <= '0;
         state_q     <= IDLE;
         ack_q       <= '0;
         evt_valid_q <= 1'b0;
         evt_idx_q   <= '0;
         rr_ptr_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         ack_q       <= ack_d;
         evt_valid_q <= evt_valid_d;
         evt_idx_q   <= evt_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         busy_q      <= busy_d;
      end
   end

   assign ack_o       = ack_q;
   assign evt_valid_o = evt_valid_q;
   assign evt_idx_o   = evt_idx_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Directed bench for cdc_req_arbiter: vector table plus handshake sequences
// for round robin, late arrival, mid-handshake reset and protocol violation.
module tb_cdc_req_arbiter;

   logic       clk;
   logic       srst;
   logic [3:0] req;
   logic [3:0] ack;
   logic       valid;
   logic       rdy;
   logic [1:0] idx;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   cdc_req_arbiter #(.NUM_REQ(4), .SYNC_STAGES(2)) dut (
      .clk_i      (clk),
      .srst_i     (srst),
      .async_req_i(req),
      .ack_o      (ack),
      .evt_valid_o(valid),
      .evt_ready_i(rdy),
      .evt_idx_o  (idx),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       srst;
      logic [3:0] req;
      logic       rdy;
      logic       v;
      logic [1:0] idx;
      logic [3:0] ack;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic s, input logic [3:0] r, input logic y,
                      input logic v, input logic [1:0] i,
                      input logic [3:0] a, input logic b, input int n);
      vec_t t;
      t.srst = s; t.req = r; t.rdy = y;
      t.v = v; t.idx = i; t.ack = a; t.busy = b;
      for (int k = 0; k < n; k++) tbl.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      srst = 1'b1;
      step();
      srst = 1'b0;
   endtask

   // Invariants: at most one ack, never ack together with a valid event
   always @(negedge clk) begin
      if (!srst) begin
         n_vec++;
         if ((ack & (ack - 4'd1)) != 4'd0 || (valid && ack != 4'd0)) begin
            n_err++;
            $display("FAIL invariant: ack=%b valid=%b", ack, valid);
         end
      end
   end

   int         grants[$];
   logic       pv;
   int         budget;
   logic [1:0] exp_seq [6];

   initial begin
      srst = 1'b1;
      req  = '0;
      rdy  = 1'b1;

      // single request on index 2, then backpressured request on index 1
      add(1, 4'h0, 1, 0, 0, 4'h0, 0, 1);
      add(0, 4'h4, 1, 0, 0, 4'h0, 0, 2);
      add(0, 4'h4, 1, 1, 2, 4'h0, 1, 1);
      add(0, 4'h4, 1, 0, 2, 4'h4, 1, 1);
      add(0, 4'h0, 1, 0, 2, 4'h4, 1, 2);
      add(0, 4'h0, 1, 0, 2, 4'h0, 0, 2);
      add(0, 4'h2, 0, 0, 2, 4'h0, 0, 2);
      add(0, 4'h2, 0, 1, 1, 4'h0, 1, 11);
      add(0, 4'h2, 1, 0, 1, 4'h2, 1, 1);
      add(0, 4'h0, 1, 0, 1, 4'h2, 1, 2);
      add(0, 4'h0, 1, 0, 1, 4'h0, 0, 1);

      for (int k = 0; k < tbl.size(); k++) begin
         srst = tbl[k].srst;
         req  = tbl[k].req;
         rdy  = tbl[k].rdy;
         step();
         chk($sformatf("v%0d.valid", k), 32'(valid), 32'(tbl[k].v));
         chk($sformatf("v%0d.idx", k), 32'(idx), 32'(tbl[k].idx));
         chk($sformatf("v%0d.ack", k), 32'(ack), 32'(tbl[k].ack));
         chk($sformatf("v%0d.busy", k), 32'(busy), 32'(tbl[k].busy));
      end

      // round robin with four self-acking requesters
      req = '0;
      rdy = 1'b1;
      do_reset();
      req = 4'hf;
      pv  = 1'b0;
      budget = 300;
      while (grants.size() < 6 && budget > 0) begin
         step();
         budget--;
         if (valid && !pv) grants.push_back(int'(idx));
         pv = valid;
         for (int i = 0; i < 4; i++) req[i] = ~ack[i];
      end
      chk("rr.timeout", 32'(budget > 0), 32'd1);
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int k = 0; k < 6; k++) begin
         if (k < grants.size())
            chk($sformatf("rr.grant%0d", k), 32'(grants[k]), 32'(exp_seq[k]));
      end

      // late arrival of req[3] while req[0] waits for its drop
      req = '0;
      do_reset();
      req = 4'h1;
      budget = 20;
      while (!ack[0] && budget > 0) begin
         step();
         budget--;
      end
      chk("late.ack0", 32'(ack[0]), 32'd1);
      req = 4'h8;
      step();
      step();
      chk("late.ack0_held", 32'(ack), 32'h1);
      step();
      chk("late.ack0_fall", 32'(ack), 32'h0);
      chk("late.idle", 32'(busy), 32'd0);
      step();
      chk("late.valid3", 32'(valid), 32'd1);
      chk("late.idx3", 32'(idx), 32'd3);

      // reset pulse during WAIT_LO with req[1] still held
      req = '0;
      do_reset();
      req = 4'h2;
      budget = 20;
      while (!ack[1] && budget > 0) begin
         step();
         budget--;
      end
      chk("rst.ack1", 32'(ack[1]), 32'd1);
      do_reset();
      chk("rst.ack_clr", 32'(ack), 32'h0);
      chk("rst.busy_clr", 32'(busy), 32'd0);
      step();
      step();
      chk("rst.not_yet", 32'(valid), 32'd0);
      step();
      chk("rst.revalid", 32'(valid), 32'd1);
      chk("rst.reidx", 32'(idx), 32'd1);

      // req[2] withdrawn while its event is still being offered
      req = '0;
      rdy = 1'b0;
      do_reset();
      req = 4'h4;
      budget = 20;
      while (!valid && budget > 0) begin
         step();
         budget--;
      end
      chk("viol.valid", 32'(valid), 32'd1);
      req = '0;
      for (int k = 0; k < 4; k++) step();
      chk("viol.hold_valid", 32'(valid), 32'd1);
      chk("viol.hold_idx", 32'(idx), 32'd2);
      chk("viol.no_ack", 32'(ack), 32'h0);
      rdy = 1'b1;
      step();
      chk("viol.ack2", 32'(ack), 32'h4);
      chk("viol.valid_lo", 32'(valid), 32'd0);
      step();
      chk("viol.ack_clr", 32'(ack), 32'h0);
      chk("viol.idle", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
